shift_add_mult_ctrl: RTL and testbench

//   Sequential shift-and-add multiplier controller. Sits directly upstream of the

---
 rtl/shift_add_mult_ctrl.sv | 110 +++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiplier controller driving an external combinational left-shifter.
// One partial product per cycle; product_o is valid with a one-cycle done_o pulse WIDTH+1 cycles after start.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   shf_a_o,
  output logic [WIDTH-1:0]   shf_b_o,
  input  logic [2*WIDTH-1:0] shf_c_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   m_shr;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_k;

  // Multiplier bit k selects whether the shifter's a<<k term is accumulated.
  assign m_shr   = m_q >> k_q;
  assign acc_sum = m_shr[0] ? (acc_q + shf_c_i) : acc_q;
  assign last_k  = (k_q == WIDTH'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    k_d     = k_q;
    m_d     = m_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          m_d     = b_i;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        if (last_k) begin
          // Product lands on the DONE-entry edge so it is valid alongside done_o.
          prod_d  = acc_sum;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      k_q     <= k_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign shf_a_o   = a_q;
  assign shf_b_o   = k_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural left-shifter in the loop.
module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] shf_a;
  logic [3:0] shf_b;
  logic [7:0] shf_c;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  assign shf_c = 8'(shf_a) << shf_b;

  shift_add_mult_ctrl #(.WIDTH(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .shf_a_o   (shf_a),
    .shf_b_o   (shf_b),
    .shf_c_i   (shf_c),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle, returns at the negedge where done is seen (or a timeout).
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                       output logic [7:0] p, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start = 1'b0;
    a     = 4'hx;
    b     = 4'hx;
    lat   = 1;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    p = product;
  endtask

  logic [7:0] p;
  int lat, bcnt, n, gap;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    chk("rst_shf_a", shf_a, 0);
    chk("rst_shf_b", shf_b, 0);

    do_op(4'd13, 4'd11, p, lat, bcnt);
    chk("t1_lat", lat, 5);
    chk("t1_prod", p, 143);
    chk("t1_busy_cycles", bcnt, 5);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_prod_hold", product, 143);

    do_op(4'd15, 4'd15, p, lat, bcnt);
    chk("t2_15x15", p, 225);
    chk("t2_15x15_lat", lat, 5);
    do_op(4'd0, 4'd9, p, lat, bcnt);
    chk("t2_0x9", p, 0);
    chk("t2_0x9_lat", lat, 5);
    do_op(4'd7, 4'd0, p, lat, bcnt);
    chk("t2_7x0", p, 0);
    chk("t2_7x0_lat", lat, 5);

    // Start held high with new operands while busy: must be ignored.
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(negedge clk);
    a = 4'd9; b = 4'd9;
    n = 0; lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_lat", lat, 5);
    chk("t3_prod", product, 15);
    start = 1'b0;
    @(negedge clk);
    chk("t3_busy_drop", busy, 0);
    chk("t3_no_second_done", done, 0);
    chk("t3_prod_hold", product, 15);
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("t3_done_count", n, 0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; a = 4'd12; b = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_prod", product, 0);
    chk("t4_done", done, 0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("t4_no_done", n, 0);
    do_op(4'd2, 4'd3, p, lat, bcnt);
    chk("t4_after_prod", p, 6);
    chk("t4_after_lat", lat, 5);

    // Back-to-back with start held continuously.
    @(negedge clk);
    start = 1'b1; a = 4'd5; b = 4'd5;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_first_lat", lat, 5);
    chk("t5_prod0", product, 25);
    for (int i = 1; i <= 3; i++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (!done) chk("t5_prod_hold", product, 25);
      end while (!done && gap < 20);
      chk("t5_gap", gap, 6);
      chk("t5_prod", product, 25);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_op(4'(i), 4'(j), p, lat, bcnt);
        chk("t6_sweep", p, i * j);
      end
    end
    chk("t6_last_lat", lat, 5);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
